// File: rtl/io_uart_pkg.sv
// io_uart_pkg: shared FSM encoding, register offsets and STATUS bit positions for io_uart_tx
package io_uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  localparam logic [31:0] OFF_DATA = 32'd0;
  localparam logic [31:0] OFF_STATUS = 32'd4;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_CNT = 3;
  localparam int ST_PAR = 8;
  function automatic logic [4:0] sat5(input logic [31:0] n);
    return n > 32'd31 ? 5'd31 : n[4:0];
  endfunction
endpackage

// File: rtl/io_uart_tx_if.sv
// io_uart_tx_if: LSU store/load bus plus serial line and busy flag of the UART transmitter
interface io_uart_tx_if;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_st_data;
  logic i_st_en;
  logic [31:0] o_ld_data;
  logic o_uart_tx;
  logic o_tx_busy;
  modport master (output i_lsu_addr, i_st_data, i_st_en, input o_ld_data, o_uart_tx, o_tx_busy);
  modport slave (input i_lsu_addr, i_st_data, i_st_en, output o_ld_data, o_uart_tx, o_tx_busy);
endinterface

// File: rtl/io_tx_fifo.sv
// io_tx_fifo: power-of-two FIFO with wrap-bit pointers for full/empty detection
module io_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr;
  logic [AW:0] rd;
  assign dout = mem[rd[AW-1:0]];
  assign empty = wr == rd;
  assign full = wr[AW] != rd[AW] && wr[AW-1:0] == rd[AW-1:0];
  assign count = wr - rd;
  // pointer advance; the extra top bit tells full apart from empty
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
    end else begin
      wr <= push ? wr + (AW+1)'(1) : wr;
      rd <= pop ? rd + (AW+1)'(1) : rd;
    end
  // storage needs no reset; contents are only visible through valid pointers
  always_ff @(posedge clk)
    if (push) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped UART transmitter (DATA queues a byte, STATUS polls FIFO); UART_TX_PARITY_EN adds even parity
module io_uart_tx
  import io_uart_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7820
) (
  input logic i_clk,
  input logic i_reset,
  io_uart_tx_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  tx_state_e state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n, dout;
  logic [AW:0] count;
  logic full, empty, pop, push, ovf, par, bit_done, sel_data, sel_stat, line_n, tx;
  logic [31:0] status;
  assign sel_data = bus.i_st_en && bus.i_lsu_addr == BASE_ADDR + OFF_DATA;
  assign sel_stat = bus.i_st_en && bus.i_lsu_addr == BASE_ADDR + OFF_STATUS;
  assign push = sel_data && (!full || pop);
  assign bit_done = cnt == CW'(CLK_DIV - 1);
  assign bus.o_uart_tx = tx;
  assign bus.o_tx_busy = state != IDLE || !empty;
  io_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) fifo (
    .clk(i_clk), .rst(i_reset), .push(push), .pop(pop), .din(bus.i_st_data[7:0]),
    .dout(dout), .full(full), .empty(empty), .count(count)
  );
`ifdef UART_TX_PARITY_EN
  localparam tx_state_e AFTER_DATA = PARITY;
  localparam logic PAR_CAP = 1'b1;
  // even parity of the byte, captured as it leaves the FIFO
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) par <= 1'b0;
    else par <= pop ? ^dout : par;
`else
  localparam tx_state_e AFTER_DATA = STOP;
  localparam logic PAR_CAP = 1'b0;
  assign par = 1'b0;
`endif
  // next state, FIFO pop, shifter update and the line level for the next cycle
  always_comb begin
    state_n = state;
    idx_n = idx;
    shreg_n = shreg;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        state_n = empty ? IDLE : START;
      end
      START: begin
        state_n = bit_done ? DATA : START;
        idx_n = bit_done ? 3'd0 : idx;
      end
      DATA: if (bit_done) begin
        shreg_n = shreg >> 1;
        idx_n = idx + 3'd1;
        state_n = idx == 3'd7 ? AFTER_DATA : DATA;
      end
      PARITY: state_n = bit_done ? STOP : PARITY;
      STOP: if (bit_done) begin
        pop = !empty;
        state_n = empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
    shreg_n = pop ? dout : shreg_n;
    line_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : state_n == PARITY ? par : 1'b1;
  end
  // baud counter, FSM/shift registers, registered line and sticky overflow
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      tx <= 1'b1;
      ovf <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == IDLE || bit_done ? '0 : cnt + CW'(1);
      idx <= idx_n;
      shreg <= shreg_n;
      tx <= line_n;
      ovf <= sel_data && full && !pop ? 1'b1 : sel_stat && bus.i_st_data[ST_OVF] ? 1'b0 : ovf;
    end
  // STATUS word assembly
  always_comb begin
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_OVF] = ovf;
    status[ST_CNT +: 5] = sat5(32'(count));
    status[ST_PAR] = PAR_CAP;
  end
  assign bus.o_ld_data = bus.i_lsu_addr == BASE_ADDR + OFF_STATUS ? status : '0;
endmodule
